// File: rtl/ping_sequencer_if.sv
// Bus bundle between the ping sequencer and its controller/storage side.
// The sequencer uses the slave modport; the controlling side uses master.
interface ping_sequencer_if;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned CNT_W = 16;

    logic             start;
    logic             abort;
    logic [IDX_W-1:0] num_pings;
    logic [CNT_W-1:0] tx_cycles;
    logic [CNT_W-1:0] mic_delay;
    logic [CNT_W-1:0] capture_len;
    logic [CNT_W-1:0] ping_period;
    logic             capture_done;

    logic             transmitter_on;
    logic             mic_on;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] ping_index;
    logic             error;

    modport master (
        output start, abort, num_pings, tx_cycles, mic_delay, capture_len,
               ping_period, capture_done,
        input  transmitter_on, mic_on, busy, done, ping_index, error
    );

    modport slave (
        input  start, abort, num_pings, tx_cycles, mic_delay, capture_len,
               ping_period, capture_done,
        output transmitter_on, mic_on, busy, done, ping_index, error
    );
endinterface

// File: rtl/ping_sequencer.sv
// Ultrasonic ping sequencer: runs num_pings bursts, each with a transmit
// burst, a microphone capture window, an optional storage acknowledge wait
// and a gap that pads the ping out to ping_period cycles.
// Optional feature: define PING_SEQ_ACK_TIMEOUT_EN to abandon a sequence
// (sticky error) when the acknowledge wait reaches 65535 cycles.
module ping_sequencer (
    input  logic             clk_in,
    input  logic             reset,
    ping_sequencer_if.slave  bus
);
    localparam int unsigned IDX_W = 8;
    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PING = 3'd1;
    localparam logic [2:0] S_ACK  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] tx_q, tx_d;
    logic [CNT_W-1:0] md_q, md_d;
    logic [CNT_W-1:0] cl_q, cl_d;
    logic [CNT_W-1:0] per_q, per_d;

    logic transmitter_on_q, transmitter_on_d;
    logic mic_on_q, mic_on_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

`ifdef PING_SEQ_ACK_TIMEOUT_EN
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             error_q, error_d;
`endif

    logic [CNT_W-1:0] t_sat_inc;
    logic [CNT_W:0]   t_plus1;
    logic [CNT_W:0]   mic_end_q;
    logic [CNT_W:0]   win_end;
    logic [CNT_W:0]   mic_end_d;

    // Window end of the current ping: the later of burst end and mic window end.
    always_comb begin
        mic_end_q = {1'b0, md_q} + {1'b0, cl_q};
        win_end   = ({1'b0, tx_q} > mic_end_q) ? {1'b0, tx_q} : mic_end_q;
        t_plus1   = {1'b0, t_q} + (CNT_W+1)'(1);
        t_sat_inc = (t_q == {CNT_W{1'b1}}) ? t_q : t_q + CNT_W'(1);
    end

    // Next-state, counters, parameter latches and decoded output values.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        idx_d   = idx_q;
        n_d     = n_q;
        tx_d    = tx_q;
        md_d    = md_q;
        cl_d    = cl_q;
        per_d   = per_q;
`ifdef PING_SEQ_ACK_TIMEOUT_EN
        ack_cnt_d = ack_cnt_q;
        error_d   = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_d     = bus.num_pings;
                    tx_d    = bus.tx_cycles;
                    md_d    = bus.mic_delay;
                    cl_d    = bus.capture_len;
                    per_d   = bus.ping_period;
                    t_d     = '0;
                    idx_d   = '0;
                    state_d = (bus.num_pings != '0) ? S_PING : S_DONE;
`ifdef PING_SEQ_ACK_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end
            S_PING: begin
                t_d = t_sat_inc;
                if (t_plus1 >= win_end) begin
                    state_d = (cl_q == '0) ? S_GAP : S_ACK;
                end
`ifdef PING_SEQ_ACK_TIMEOUT_EN
                ack_cnt_d = '0;
`endif
            end
            S_ACK: begin
                t_d = t_sat_inc;
                if (bus.capture_done) begin
                    state_d = S_GAP;
                end
`ifdef PING_SEQ_ACK_TIMEOUT_EN
                else if (ack_cnt_q == CNT_W'(16'hFFFE)) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + CNT_W'(1);
                end
`endif
            end
            S_GAP: begin
                t_d = t_sat_inc;
                if (t_plus1 >= {1'b0, per_q}) begin
                    if (({1'b0, idx_q} + (IDX_W+1)'(1)) < {1'b0, n_q}) begin
                        state_d = S_PING;
                        t_d     = '0;
                        idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        // Outputs are registered copies of what the next state/counter decode to.
        mic_end_d        = {1'b0, md_d} + {1'b0, cl_d};
        transmitter_on_d = (state_d == S_PING) && (t_d < tx_d);
        mic_on_d         = (state_d == S_PING) && (t_d >= md_d) && ({1'b0, t_d} < mic_end_d);
        busy_d           = (state_d == S_PING) || (state_d == S_ACK) || (state_d == S_GAP);
        done_d           = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q          <= S_IDLE;
            t_q              <= '0;
            idx_q            <= '0;
            n_q              <= '0;
            tx_q             <= '0;
            md_q             <= '0;
            cl_q             <= '0;
            per_q            <= '0;
            transmitter_on_q <= 1'b0;
            mic_on_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
`ifdef PING_SEQ_ACK_TIMEOUT_EN
            ack_cnt_q        <= '0;
            error_q          <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            t_q              <= t_d;
            idx_q            <= idx_d;
            n_q              <= n_d;
            tx_q             <= tx_d;
            md_q             <= md_d;
            cl_q             <= cl_d;
            per_q            <= per_d;
            transmitter_on_q <= transmitter_on_d;
            mic_on_q         <= mic_on_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
`ifdef PING_SEQ_ACK_TIMEOUT_EN
            ack_cnt_q        <= ack_cnt_d;
            error_q          <= error_d;
`endif
        end
    end

    assign bus.transmitter_on = transmitter_on_q;
    assign bus.mic_on         = mic_on_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.ping_index     = idx_q;
`ifdef PING_SEQ_ACK_TIMEOUT_EN
    assign bus.error          = error_q;
`else
    assign bus.error          = 1'b0;
`endif
endmodule

// File: tb/tb_ping_sequencer.sv
// Scoreboard bench for ping_sequencer: a timeline model builds the expected
// per-cycle outputs of each sequence, the stimulus pushes them as it drives,
// and a monitor compares them against the DUT on the falling edge.
module tb_ping_sequencer;
    localparam int PH_PING = 0;
    localparam int PH_ACK  = 1;
    localparam int PH_GAP  = 2;
    localparam int PH_DONE = 3;

    logic clk = 1'b0;
    logic reset;

    ping_sequencer_if sif ();

    ping_sequencer dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (sif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        logic       busy;
        logic       tx;
        logic       mic;
        logic       done;
        logic       err;
        logic [7:0] idx;
    } exp_t;

    exp_t sb_q[$];
    exp_t tl[$];
    bit   cd_tl[$];
    int   ph_tl[$];
    bit   tl_err;

    int checks = 0;
    int errors = 0;
    int scyc   = 0;
    int mcyc   = 0;
    logic [7:0] held_idx = 8'd0;
    logic       held_err = 1'b0;

    function automatic exp_t mk(input logic b, input logic tx, input logic mic,
                                input logic dn, input logic er, input logic [7:0] ix);
        exp_t e;
        e.cyc = 0; e.busy = b; e.tx = tx; e.mic = mic; e.done = dn; e.err = er; e.idx = ix;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        scyc++;
    endtask

    task automatic expect_now(input exp_t e);
        e.cyc = scyc;
        sb_q.push_back(e);
    endtask

    task automatic rand_params();
        sif.num_pings   = 8'($urandom);
        sif.tx_cycles   = 16'($urandom);
        sif.mic_delay   = 16'($urandom);
        sif.capture_len = 16'($urandom);
        sif.ping_period = 16'($urandom);
    endtask

    task automatic drive_idle();
        sif.start        = 1'b0;
        sif.abort        = 1'b0;
        sif.capture_done = ($urandom_range(0, 3) == 0);
        rand_params();
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            tick();
            expect_now(mk(1'b0, 1'b0, 1'b0, 1'b0, held_err, held_idx));
            drive_idle();
        end
    endtask

    task automatic do_reset(input int k, input bit hold_start);
        held_idx = 8'd0;
        held_err = 1'b0;
        repeat (k) begin
            reset     = 1'b1;
            sif.start = hold_start;
            sif.abort = 1'($urandom_range(0, 1));
            tick();
            expect_now(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        end
        reset     = 1'b0;
        sif.start = 1'b0;
        sif.abort = 1'b0;
    endtask

    task automatic add(input logic b, input logic tx, input logic mic, input logic dn,
                       input logic [7:0] ix, input int ph, input bit cd);
        tl.push_back(mk(b, tx, mic, dn, 1'b0, ix));
        ph_tl.push_back(ph);
        cd_tl.push_back(cd);
    endtask

    // Timeline of one sequence; index 0 is the start cycle, 1 is the first cycle after acceptance.
    task automatic build_tl(input int n, input int tx, input int md, input int cl,
                            input int per, input int ack_dly);
        int w, g, gl, a;
        tl.delete(); cd_tl.delete(); ph_tl.delete();
        tl_err = 1'b0;
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, -1, 1'b0);
        if (n == 0) begin
            add(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, PH_DONE, ($urandom_range(0, 3) == 0));
            return;
        end
        w = tx;
        if (md + cl > w) w = md + cl;
        if (w < 1) w = 1;
        for (int k = 0; k < n; k++) begin
            for (int t = 0; t < w; t++)
                add(1'b1, (t < tx), (t >= md && t < md + cl), 1'b0, 8'(k), PH_PING,
                    ($urandom_range(0, 3) == 0));
            g = w;
            if (cl != 0) begin
                a = (ack_dly < 0) ? $urandom_range(0, 3) : ack_dly;
`ifdef PING_SEQ_ACK_TIMEOUT_EN
                if (a >= 65535) begin
                    for (int j = 0; j < 65535; j++)
                        add(1'b1, 1'b0, 1'b0, 1'b0, 8'(k), PH_ACK, 1'b0);
                    tl_err = 1'b1;
                    return;
                end
`endif
                for (int j = 0; j <= a; j++)
                    add(1'b1, 1'b0, 1'b0, 1'b0, 8'(k), PH_ACK, (j == a));
                g = w + a + 1;
            end
            gl = (per - g > 1) ? per - g : 1;
            for (int j = 0; j < gl; j++)
                add(1'b1, 1'b0, 1'b0, 1'b0, 8'(k), PH_GAP, ($urandom_range(0, 3) == 0));
        end
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'(n - 1), PH_DONE, ($urandom_range(0, 3) == 0));
    endtask

    // kill_kind: 0 none, 1 abort, 2 stop here so the caller can apply reset.
    task automatic run_seq(input int n, input int tx, input int md, input int cl, input int per,
                           input int ack_dly, input int kill_kind, input int kill_ph,
                           input int kill_ping, input int kill_off);
        int kill_r, last;
        build_tl(n, tx, md, cl, per, ack_dly);
        last   = tl.size() - 1;
        kill_r = -1;
        if (kill_kind != 0) begin
            for (int r = 1; r <= last; r++)
                if (kill_r < 0 && ph_tl[r] == kill_ph && int'(tl[r].idx) == kill_ping)
                    kill_r = (r + kill_off > last) ? last : r + kill_off;
        end
        sif.start        = 1'b1;
        sif.abort        = 1'b0;
        sif.num_pings    = 8'(n);
        sif.tx_cycles    = 16'(tx);
        sif.mic_delay    = 16'(md);
        sif.capture_len  = 16'(cl);
        sif.ping_period  = 16'(per);
        sif.capture_done = 1'($urandom_range(0, 1));
        held_err = 1'b0;
        for (int r = 1; r <= last; r++) begin
            tick();
            expect_now(tl[r]);
            if (r == kill_r) begin
                held_idx = tl[r].idx;
                if (kill_kind == 1) begin
                    sif.abort        = 1'b1;
                    sif.start        = 1'($urandom_range(0, 1));
                    sif.capture_done = 1'($urandom_range(0, 1));
                end
                return;
            end
            sif.start        = 1'($urandom_range(0, 1));
            sif.abort        = 1'b0;
            sif.capture_done = cd_tl[r];
            rand_params();
        end
        held_idx = tl[last].idx;
        held_err = tl_err;
        tick();
        expect_now(mk(1'b0, 1'b0, 1'b0, 1'b0, held_err, held_idx));
        drive_idle();
    endtask

    // Monitor: compare each expected record in the cycle it is tagged with.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            mcyc++;
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc < mcyc) begin
                e = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL stale_entry cyc=%0d expected record for cycle %0d never compared", mcyc, e.cyc);
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == mcyc) begin
                e = sb_q.pop_front();
                checks++;
                if (sif.busy !== e.busy || sif.transmitter_on !== e.tx || sif.mic_on !== e.mic ||
                    sif.done !== e.done || sif.error !== e.err || sif.ping_index !== e.idx) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got busy=%b tx=%b mic=%b done=%b err=%b idx=%0d want busy=%b tx=%b mic=%b done=%b err=%b idx=%0d",
                             mcyc, sif.busy, sif.transmitter_on, sif.mic_on, sif.done, sif.error,
                             sif.ping_index, e.busy, e.tx, e.mic, e.done, e.err, e.idx);
                end
            end
        end
    end

    initial begin
        int n, kk;
        reset = 1'b1;
        drive_idle();
        do_reset(3, 1'b0);
        idle_cycles(2);

        // Single ping, acknowledge two cycles after ACK entry.
        run_seq(1, 4, 2, 3, 20, 2, 0, 0, 0, 0);
        idle_cycles(3);
        // Three pings at 10-cycle spacing with prompt acknowledge.
        run_seq(3, 3, 1, 2, 10, 0, 0, 0, 0, 0);
        idle_cycles(2);
        // Zero pings: straight to done.
        run_seq(0, 5, 1, 2, 10, -1, 0, 0, 0, 0);
        idle_cycles(2);
        // All-zero timing: one-cycle PING and GAP, no ACK.
        run_seq(2, 0, 0, 0, 0, -1, 0, 0, 0, 0);
        idle_cycles(2);
        // Window plus ACK longer than the period: GAP shrinks to one cycle.
        run_seq(2, 12, 3, 10, 5, 3, 0, 0, 0, 0);
        idle_cycles(2);
        // Abort mid-PING of ping 1, then a full sequence.
        run_seq(3, 4, 2, 3, 15, -1, 1, PH_PING, 1, 2);
        idle_cycles(3);
        run_seq(3, 4, 2, 3, 15, -1, 0, 0, 0, 0);
        idle_cycles(2);
        // Reset during GAP with start held high.
        run_seq(2, 3, 1, 2, 12, -1, 2, PH_GAP, 0, 1);
        do_reset(3, 1'b1);
        run_seq(2, 3, 1, 2, 12, -1, 0, 0, 0, 0);
        idle_cycles(2);

        // Randomized sequences with occasional abort or reset.
        repeat (40) begin
            n  = $urandom_range(0, 4);
            kk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            run_seq(n, $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 6),
                    $urandom_range(0, 30), -1, kk, $urandom_range(0, 3),
                    (n > 0) ? $urandom_range(0, n - 1) : 0, $urandom_range(0, 2));
            if (kk == 2) do_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(1, 3));
        end

        // Acknowledge withheld past 65535 cycles.
        run_seq(1, 2, 0, 1, 4, 65600, 0, 0, 0, 0);
        idle_cycles(5);

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d entries left required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
